// File: rtl/pll_cfg_pkg.sv
// Shared types and helpers for the PLL configuration sequencer.
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_GATE,
        ST_APPLY,
        ST_OFF
    } pll_cfg_state_t;

    localparam int PLL_CFG_W = 4;
    localparam logic [PLL_CFG_W-1:0] PLL_CFG_DEFAULT = 4'h1;

    // Counter must hold the longest window without wrapping.
    function automatic int pll_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_settle_timer.sv
// Saturating up-counter with two reach compares, shared by the gate and settle windows.
module pll_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_hit,
    output logic             o_limit
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit   = (r_cnt >= i_last);
    assign o_limit = (r_cnt >= i_limit);

endmodule

// File: rtl/pll_cfg_ctrl.sv
// Gated clk_cfg sequencer upstream of the pll.
// Optional lock-wait/timeout supervision is enabled with PLL_CFG_LOCK_EN.
module pll_cfg_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int               CFG_W       = PLL_CFG_W,
    parameter logic [CFG_W-1:0] DEFAULT_CFG = CFG_W'(PLL_CFG_DEFAULT),
    parameter int               GATE_CYC    = 2,
    parameter int               SETTLE_CYC  = 256
`ifdef PLL_CFG_LOCK_EN
    ,
    parameter int               LOCK_TIMEOUT = 4096
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CFG_W-1:0] req_cfg,
    output logic [CFG_W-1:0] clk_cfg,
    output logic             clk_gate_en,
    output logic             cfg_stable
`ifdef PLL_CFG_LOCK_EN
    ,
    input  logic             pll_lock,
    output logic             lock_err
`endif
);

`ifdef PLL_CFG_LOCK_EN
    localparam int CNT_W = pll_cnt_width(GATE_CYC, LOCK_TIMEOUT);
`else
    localparam int CNT_W = pll_cnt_width(GATE_CYC, SETTLE_CYC);
`endif

    pll_cfg_state_t   r_state;
    logic [CFG_W-1:0] r_clk_cfg;
    logic [CFG_W-1:0] r_pend_cfg;
    logic             r_gate_en;
    logic             r_stable;
    logic             w_tmr_clear;
    logic             w_hit;
    logic             w_limit;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_limit_val;

    // Counter runs only in the timed states, so it reads 0 on entry to each.
    assign w_tmr_clear = !((r_state == ST_GATE) || (r_state == ST_SETTLE));

`ifdef PLL_CFG_LOCK_EN
    logic r_lock_err;
    assign w_last      = (r_state == ST_GATE) ? CNT_W'(GATE_CYC - 1) : CNT_W'(SETTLE_CYC - 1);
    assign w_limit_val = CNT_W'(LOCK_TIMEOUT - 1);
    assign lock_err    = r_lock_err;
`else
    assign w_last      = CNT_W'(GATE_CYC - 1);
    assign w_limit_val = CNT_W'(SETTLE_CYC - 1);
`endif

    pll_settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_tmr_clear),
        .i_en    (!w_tmr_clear),
        .i_last  (w_last),
        .i_limit (w_limit_val),
        .o_hit   (w_hit),
        .o_limit (w_limit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_SETTLE;
            r_clk_cfg  <= DEFAULT_CFG;
            r_pend_cfg <= DEFAULT_CFG;
            r_gate_en  <= 1'b0;
            r_stable   <= 1'b0;
`ifdef PLL_CFG_LOCK_EN
            r_lock_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                // In OFF clk_cfg is 0, so "differs from clk_cfg" also covers its no-op rule.
                ST_IDLE, ST_OFF: begin
                    if (req_valid && (req_cfg != r_clk_cfg)) begin
                        r_pend_cfg <= req_cfg;
                        r_gate_en  <= 1'b0;
                        r_stable   <= 1'b0;
`ifdef PLL_CFG_LOCK_EN
                        r_lock_err <= 1'b0;
`endif
                        r_state    <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (w_hit) begin
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_clk_cfg <= r_pend_cfg;
                    r_state   <= (r_pend_cfg == '0) ? ST_OFF : ST_SETTLE;
                end
                ST_SETTLE: begin
`ifdef PLL_CFG_LOCK_EN
                    if (w_hit && pll_lock) begin
                        r_gate_en <= 1'b1;
                        r_stable  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_limit) begin
                        r_lock_err <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
`else
                    if (w_limit) begin
                        r_gate_en <= 1'b1;
                        r_stable  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
`endif
                end
                default: begin
                    r_state <= ST_SETTLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE) || (r_state == ST_OFF);
    assign clk_cfg     = r_clk_cfg;
    assign clk_gate_en = r_gate_en;
    assign cfg_stable  = r_stable;

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// Directed scoreboard bench for pll_cfg_ctrl (GATE_CYC=2, SETTLE_CYC=8).
module tb_pll_cfg_ctrl;

    localparam int G = 2;
    localparam int S = 8;
    localparam logic [3:0] DEF = 4'h1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_cfg = '0;
    logic       req_ready;
    logic [3:0] clk_cfg;
    logic       clk_gate_en;
    logic       cfg_stable;
`ifdef PLL_CFG_LOCK_EN
    logic       pll_lock = 1'b1;
    logic       lock_err;
`endif

    always #5 clk = ~clk;

    pll_cfg_ctrl #(
        .CFG_W       (4),
        .DEFAULT_CFG (DEF),
        .GATE_CYC    (G),
        .SETTLE_CYC  (S)
`ifdef PLL_CFG_LOCK_EN
        ,
        .LOCK_TIMEOUT (16)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cfg     (req_cfg),
        .clk_cfg     (clk_cfg),
        .clk_gate_en (clk_gate_en),
        .cfg_stable  (cfg_stable)
`ifdef PLL_CFG_LOCK_EN
        ,
        .pll_lock    (pll_lock),
        .lock_err    (lock_err)
`endif
    );

    typedef struct {
        logic [3:0] cfg;
        logic       gate;
        logic       stable;
        logic       ready;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [3:0] model_cfg = DEF;

    task automatic push(input logic [3:0] c, input logic g, input logic s,
                        input logic r, input string t);
        exp_t e;
        e.cfg = c; e.gate = g; e.stable = s; e.ready = r; e.tag = t;
        sb.push_back(e);
    endtask

    // One clock edge; sample 1 time unit later and score against the oldest expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (clk_cfg === e.cfg) else begin
                bad++; $error("FAIL %s clk_cfg got=%h exp=%h", e.tag, clk_cfg, e.cfg);
            end
            total++;
            assert (clk_gate_en === e.gate) else begin
                bad++; $error("FAIL %s clk_gate_en got=%b exp=%b", e.tag, clk_gate_en, e.gate);
            end
            total++;
            assert (cfg_stable === e.stable) else begin
                bad++; $error("FAIL %s cfg_stable got=%b exp=%b", e.tag, cfg_stable, e.stable);
            end
            total++;
            assert (req_ready === e.ready) else begin
                bad++; $error("FAIL %s req_ready got=%b exp=%b", e.tag, req_ready, e.ready);
            end
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) tick();
    endtask

    task automatic push_powerup();
        for (int i = 1; i <= S; i++)
            push(DEF, i == S, i == S, i == S, "powerup");
    endtask

    // Expected trace after edge E+j, j=0 being the accept edge.
    task automatic push_change(input logic [3:0] oldc, input logic [3:0] newc,
                               input int last_j, input string t);
        logic [3:0] c;
        logic       up;
        for (int j = 0; j <= last_j; j++) begin
            c  = (j >= G + 1) ? newc : oldc;
            up = (newc != 4'h0) && (j == G + S + 1);
            push(c, up, up, up || ((newc == 4'h0) && (j >= G + 1)), t);
        end
    endtask

    task automatic request(input logic [3:0] c, input string t);
        req_cfg   = c;
        req_valid = 1'b1;
        if (c == model_cfg) begin
            for (int k = 0; k < 4; k++)
                push(c, c != 4'h0, c != 4'h0, 1'b1, t);
        end else if (c == 4'h0) begin
            push_change(model_cfg, c, G + 5, t);
        end else begin
            push_change(model_cfg, c, G + S + 1, t);
        end
        model_cfg = c;
        drain();
    endtask

    initial begin
        push(DEF, 1'b0, 1'b0, 1'b0, "reset");
        tick();
        push(DEF, 1'b0, 1'b0, 1'b0, "reset");
        tick();
        rst_n = 1'b1;
        push_powerup();
        drain();

        request(4'h5, "req5");
        request(4'h5, "noop5");
        request(4'h0, "req0");
        request(4'h0, "noop0");
        request(4'h3, "req3_from_off");

        // Reset lands during the fifth SETTLE cycle of a change to 9.
        req_cfg   = 4'h9;
        req_valid = 1'b1;
        push_change(model_cfg, 4'h9, G + 5, "req9_partial");
        drain();
        rst_n = 1'b0;
        push(DEF, 1'b0, 1'b0, 1'b0, "mid_settle_reset");
        tick();
        rst_n = 1'b1;
        model_cfg = DEF;
        push_powerup();
        drain();

`ifdef PLL_CFG_LOCK_EN
        pll_lock  = 1'b0;
        req_cfg   = 4'h7;
        req_valid = 1'b1;
        for (int j = 0; j <= G + 1 + 16; j++)
            push((j >= G + 1) ? 4'h7 : model_cfg, 1'b0, 1'b0, j == G + 1 + 16, "lock_timeout");
        model_cfg = 4'h7;
        drain();
        total++;
        assert (lock_err === 1'b1) else begin
            bad++; $error("FAIL lock_err_set got=%b exp=1", lock_err);
        end
        pll_lock = 1'b1;
        request(4'h2, "relock");
        total++;
        assert (lock_err === 1'b0) else begin
            bad++; $error("FAIL lock_err_clear got=%b exp=0", lock_err);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
